// File: rtl/beat_sequencer.sv
// beat_sequencer: run-control and beat scheduling for the metronome datapath.
// IDLE/RUN/PAUSE FSM owning a 3-digit BCD tick counter (000..124 per beat),
// the beat index within the measure, and the per-beat note gate.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   tick                  one-clk timebase strobe; count advances only on tick
//   start, pause, stop    level commands, priority stop > pause > start
//   meter[1:0]            beats per measure: 00=2, 01=3, 10=4, 11=6
//   length[1:0]           note gate: 00=75 ticks, 01=50, 10=25, 11=full beat
//   cnt2, cnt1, cnt0      BCD tick count (hundreds/tens/units), registered
//   beat[2:0]             beat index within the measure, registered
//   beat_pulse, downbeat  one-clk strobes at beat start / beat 0 start
//   note_on               gate, combinational from registered count and state
//   running               high in RUN, registered
//   state[1:0]            00=IDLE, 01=RUN, 10=PAUSE
module beat_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic [1:0] meter,
  input  logic [1:0] length,
  output logic [3:0] cnt2,
  output logic [3:0] cnt1,
  output logic [3:0] cnt0,
  output logic [2:0] beat,
  output logic       beat_pulse,
  output logic       downbeat,
  output logic       note_on,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BEAT_W  = 3;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  state_t              r_state;
  logic [DIGIT_W-1:0]  r_cnt2, r_cnt1, r_cnt0;
  logic [BEAT_W-1:0]   r_beat;
  logic [SEL_W-1:0]    r_meter_l, r_length_l;
  logic                r_beat_pulse, r_downbeat, r_running;

  state_t              w_state_nxt;
  logic [DIGIT_W-1:0]  w_cnt2_nxt, w_cnt1_nxt, w_cnt0_nxt;
  logic [BEAT_W-1:0]   w_beat_nxt;
  logic [SEL_W-1:0]    w_meter_nxt, w_length_nxt;
  logic                w_beat_pulse_nxt, w_downbeat_nxt;
  logic                w_clear;

  logic [BEAT_W-1:0]   w_last_beat;
  logic                w_cnt_ok, w_cnt_end, w_wrap;
  logic [DIGIT_W-1:0]  w_lim_t, w_lim_u;
  logic                w_full, w_below;

  // Index of the last beat in the measure for the latched meter.
  always_comb begin
    w_last_beat = BEAT_W'(3);
    case (r_meter_l)
      2'b00:   w_last_beat = BEAT_W'(1);
      2'b01:   w_last_beat = BEAT_W'(2);
      2'b10:   w_last_beat = BEAT_W'(3);
      default: w_last_beat = BEAT_W'(5);
    endcase
  end

  // Legal count: every digit BCD and total <= 124. Anything else wraps on the next tick.
  assign w_cnt_ok = (r_cnt0 <= DIGIT_W'(9)) && (r_cnt1 <= DIGIT_W'(9)) &&
                    ((r_cnt2 == DIGIT_W'(0)) ||
                     ((r_cnt2 == DIGIT_W'(1)) &&
                      ((r_cnt1 < DIGIT_W'(2)) ||
                       ((r_cnt1 == DIGIT_W'(2)) && (r_cnt0 <= DIGIT_W'(4))))));
  assign w_cnt_end = (r_cnt2 == DIGIT_W'(1)) && (r_cnt1 == DIGIT_W'(2)) &&
                     (r_cnt0 == DIGIT_W'(4));
  assign w_wrap    = w_cnt_end || !w_cnt_ok;

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt2_nxt       = r_cnt2;
    w_cnt1_nxt       = r_cnt1;
    w_cnt0_nxt       = r_cnt0;
    w_beat_nxt       = r_beat;
    w_meter_nxt      = r_meter_l;
    w_length_nxt     = r_length_l;
    w_beat_pulse_nxt = 1'b0;
    w_downbeat_nxt   = 1'b0;
    w_clear          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (stop) begin
          w_clear = 1'b1;
        end else if (pause) begin
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_state_nxt      = S_RUN;
          w_cnt2_nxt       = '0;
          w_cnt1_nxt       = '0;
          w_cnt0_nxt       = '0;
          w_beat_nxt       = '0;
          w_meter_nxt      = meter;
          w_length_nxt     = length;
          w_beat_pulse_nxt = 1'b1;
          w_downbeat_nxt   = 1'b1;
        end
      end

      S_RUN: begin
        if (stop) begin
          w_clear = 1'b1;
        end else if (pause) begin
          w_state_nxt = S_PAUSE;
        end else if (tick) begin
          if (w_wrap) begin
            w_cnt2_nxt       = '0;
            w_cnt1_nxt       = '0;
            w_cnt0_nxt       = '0;
            w_beat_pulse_nxt = 1'b1;
            w_length_nxt     = length;
            // >= guards against an out-of-range index rather than relying on ==.
            if (r_beat >= w_last_beat) begin
              w_beat_nxt     = '0;
              w_downbeat_nxt = 1'b1;
              w_meter_nxt    = meter;
            end else begin
              w_beat_nxt = r_beat + BEAT_W'(1);
            end
          end else if (r_cnt0 == DIGIT_W'(9)) begin
            w_cnt0_nxt = '0;
            if (r_cnt1 == DIGIT_W'(9)) begin
              w_cnt1_nxt = '0;
              w_cnt2_nxt = r_cnt2 + DIGIT_W'(1);
            end else begin
              w_cnt1_nxt = r_cnt1 + DIGIT_W'(1);
            end
          end else begin
            w_cnt0_nxt = r_cnt0 + DIGIT_W'(1);
          end
        end
      end

      S_PAUSE: begin
        if (stop) begin
          w_clear = 1'b1;
        end else if (pause) begin
          w_state_nxt = S_PAUSE;
        end else if (start) begin
          w_state_nxt = S_RUN;
        end
      end

      default: begin
        w_clear = 1'b1;
      end
    endcase

    // Full clear back to IDLE, same as reset.
    if (w_clear) begin
      w_state_nxt      = S_IDLE;
      w_cnt2_nxt       = '0;
      w_cnt1_nxt       = '0;
      w_cnt0_nxt       = '0;
      w_beat_nxt       = '0;
      w_meter_nxt      = '0;
      w_length_nxt     = '0;
      w_beat_pulse_nxt = 1'b0;
      w_downbeat_nxt   = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt2       <= '0;
      r_cnt1       <= '0;
      r_cnt0       <= '0;
      r_beat       <= '0;
      r_meter_l    <= '0;
      r_length_l   <= '0;
      r_beat_pulse <= 1'b0;
      r_downbeat   <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt2       <= w_cnt2_nxt;
      r_cnt1       <= w_cnt1_nxt;
      r_cnt0       <= w_cnt0_nxt;
      r_beat       <= w_beat_nxt;
      r_meter_l    <= w_meter_nxt;
      r_length_l   <= w_length_nxt;
      r_beat_pulse <= w_beat_pulse_nxt;
      r_downbeat   <= w_downbeat_nxt;
      r_running    <= (w_state_nxt == S_RUN);
    end
  end

  // Gate limit as tens/units digits so the compare stays decimal on the BCD count.
  always_comb begin
    w_full  = 1'b0;
    w_lim_t = DIGIT_W'(7);
    w_lim_u = DIGIT_W'(5);
    case (r_length_l)
      2'b00: begin w_lim_t = DIGIT_W'(7); w_lim_u = DIGIT_W'(5); end
      2'b01: begin w_lim_t = DIGIT_W'(5); w_lim_u = DIGIT_W'(0); end
      2'b10: begin w_lim_t = DIGIT_W'(2); w_lim_u = DIGIT_W'(5); end
      default: w_full = 1'b1;
    endcase
  end

  assign w_below = (r_cnt2 == DIGIT_W'(0)) &&
                   ((r_cnt1 < w_lim_t) || ((r_cnt1 == w_lim_t) && (r_cnt0 < w_lim_u)));

  assign note_on    = r_running && (w_full || w_below);
  assign cnt2       = r_cnt2;
  assign cnt1       = r_cnt1;
  assign cnt0       = r_cnt0;
  assign beat       = r_beat;
  assign beat_pulse = r_beat_pulse;
  assign downbeat   = r_downbeat;
  assign running    = r_running;
  assign state      = r_state;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed self-checking bench for beat_sequencer: start, BCD carries, beat and
// measure wraps, pause/resume, mid-measure meter/length change, combined
// commands, and asynchronous reset mid-beat. One tick every 4 clk.
module tb_beat_sequencer;

  logic       clk, rst_n, tick, start, pause, stop;
  logic [1:0] meter, length;
  logic [3:0] cnt2, cnt1, cnt0;
  logic [2:0] beat;
  logic       beat_pulse, downbeat, note_on, running;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  beat_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .pause(pause),
    .stop(stop), .meter(meter), .length(length), .cnt2(cnt2), .cnt1(cnt1),
    .cnt0(cnt0), .beat(beat), .beat_pulse(beat_pulse), .downbeat(downbeat),
    .note_on(note_on), .running(running), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic logic [11:0] bcd(input int v);
    bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick1();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // Ticks from..to, checking the BCD digits and the gate after each.
  task automatic ticks_chk(input int from, input int to, input int lim);
    for (int i = from; i <= to; i++) begin
      tick1();
      chk("count", 32'({cnt2, cnt1, cnt0}), 32'(bcd(i)));
      chk("note_on", 32'(note_on), 32'(i < lim));
      cyc(3);
    end
  endtask

  // The 125th tick of a beat: count to 000 with strobes for exactly one clk.
  task automatic wrap_chk(input int exp_beat, input bit exp_down);
    tick1();
    chk("wrap_count", 32'({cnt2, cnt1, cnt0}), 32'(0));
    chk("wrap_pulse", 32'(beat_pulse), 32'(1));
    chk("wrap_down", 32'(downbeat), 32'(exp_down));
    chk("wrap_beat", 32'(beat), 32'(exp_beat));
    chk("wrap_note", 32'(note_on), 32'(1));
    cyc(1);
    chk("pulse_1clk", 32'(beat_pulse), 32'(0));
    chk("down_1clk", 32'(downbeat), 32'(0));
    cyc(2);
  endtask

  task automatic run_beat(input int exp_beat, input bit exp_down, input int lim);
    ticks_chk(1, 124, lim);
    wrap_chk(exp_beat, exp_down);
  endtask

  task automatic start_chk(input string tag);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_state"}, 32'(state), 32'(1));
    chk({tag, "_count"}, 32'({cnt2, cnt1, cnt0}), 32'(0));
    chk({tag, "_beat"}, 32'(beat), 32'(0));
    chk({tag, "_pulse"}, 32'(beat_pulse), 32'(1));
    chk({tag, "_down"}, 32'(downbeat), 32'(1));
    chk({tag, "_note"}, 32'(note_on), 32'(1));
    chk({tag, "_running"}, 32'(running), 32'(1));
    cyc(1);
    chk({tag, "_pulse_1clk"}, 32'(beat_pulse), 32'(0));
    cyc(2);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(0));
    chk({tag, "_count"}, 32'({cnt2, cnt1, cnt0}), 32'(0));
    chk({tag, "_beat"}, 32'(beat), 32'(0));
    chk({tag, "_note"}, 32'(note_on), 32'(0));
    chk({tag, "_running"}, 32'(running), 32'(0));
    chk({tag, "_pulse"}, 32'(beat_pulse), 32'(0));
    chk({tag, "_down"}, 32'(downbeat), 32'(0));
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    meter = 2'b10; length = 2'b00;
    cyc(2);
    idle_chk("reset");
    rst_n = 1'b1;
    cyc(2);

    // 4/4, 75-tick gate: four beats, downbeat again after 500 ticks.
    start_chk("start1");
    run_beat(1, 1'b0, 75);
    run_beat(2, 1'b0, 75);
    run_beat(3, 1'b0, 75);
    run_beat(0, 1'b1, 75);
    run_beat(1, 1'b0, 75);
    run_beat(2, 1'b0, 75);

    // Pause at 063 of beat 2 with a coincident tick; ticks ignored while paused.
    ticks_chk(1, 63, 75);
    chk("pre_pause_beat", 32'(beat), 32'(2));
    pause = 1'b1; tick = 1'b1;
    @(posedge clk);
    #1;
    pause = 1'b0; tick = 1'b0;
    chk("pause_state", 32'(state), 32'(2));
    chk("pause_count", 32'({cnt2, cnt1, cnt0}), 32'(bcd(63)));
    chk("pause_note", 32'(note_on), 32'(0));
    chk("pause_running", 32'(running), 32'(0));
    repeat (20) begin
      tick1();
      chk("paused_count", 32'({cnt2, cnt1, cnt0}), 32'(bcd(63)));
      chk("paused_pulse", 32'(beat_pulse), 32'(0));
      cyc(3);
    end
    chk("paused_beat", 32'(beat), 32'(2));
    chk("paused_note", 32'(note_on), 32'(0));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("resume_state", 32'(state), 32'(1));
    chk("resume_pulse", 32'(beat_pulse), 32'(0));
    chk("resume_count", 32'({cnt2, cnt1, cnt0}), 32'(bcd(63)));
    chk("resume_note", 32'(note_on), 32'(1));
    cyc(2);
    tick1();
    chk("resume_tick", 32'({cnt2, cnt1, cnt0}), 32'(bcd(64)));
    chk("resume_tick_pulse", 32'(beat_pulse), 32'(0));
    cyc(3);
    ticks_chk(65, 124, 75);
    wrap_chk(3, 1'b0);
    run_beat(0, 1'b1, 75);
    run_beat(1, 1'b0, 75);

    // Meter 4->2 and length 75->25 mid beat 1: length from next beat, meter at measure wrap.
    ticks_chk(1, 60, 75);
    meter = 2'b00; length = 2'b10;
    ticks_chk(61, 124, 75);
    wrap_chk(2, 1'b0);
    run_beat(3, 1'b0, 25);
    run_beat(0, 1'b1, 25);
    run_beat(1, 1'b0, 25);
    run_beat(0, 1'b1, 25);

    // All commands plus tick in one RUN cycle: stop wins, full clear.
    ticks_chk(1, 30, 25);
    stop = 1'b1; pause = 1'b1; start = 1'b1; tick = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0; pause = 1'b0; start = 1'b0; tick = 1'b0;
    idle_chk("combo");
    cyc(3);
    idle_chk("combo_hold");

    // Asynchronous reset between clock edges, mid-beat.
    meter = 2'b01; length = 2'b01;
    start_chk("start2");
    ticks_chk(1, 40, 50);
    #2;
    rst_n = 1'b0;
    #1;
    idle_chk("async_rst");
    #3;
    rst_n = 1'b1;
    cyc(2);
    idle_chk("post_rst");

    // Restart with full-beat gate: note_on high across the whole beat.
    meter = 2'b11; length = 2'b11;
    start_chk("start3");
    run_beat(1, 1'b0, 125);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
